ifu_queue: RTL and testbench

Parametrised instruction fetch unit for the pipelined MIPS core. It owns the fetch PC and issues word requests to an instruction memory port with a variable response latency. Fetched {pc, instruction} pairs are buffered in a DEPTH-entry queue ahead of the IF/ID register. Later stages steer fetch with a single redirect port for taken branches, jal and jr, so the block never needs branch operands itself.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_queue_fetch_fifo.sv | 62 ++++++
 rtl/ifu_queue.sv | 119 +++++++++++
 tb/tb_ifu_queue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states, queue entry
// layout and the default boot PC.
package ifu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } queue_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_queue_fetch_fifo.sv
// Circular buffer of fetched {pc, instruction} pairs. The head is read
// combinationally so it can drive the IF/ID register in the push+1 cycle.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  queue_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output queue_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    queue_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage carries no reset; stale contents are never visible because
    // the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap-around is the natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/ifu_queue.sv
// Instruction fetch unit: owns the fetch PC, keeps one request outstanding to
// the instruction memory and buffers responses ahead of the IF/ID register.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_ins,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc8,
    output logic [$clog2(DEPTH):0] occupancy
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic [31:0]  fpc_reg;
    logic [31:0]  fpc_next;
    logic [31:0]  req_pc_reg;

    logic         accept;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    queue_entry_t push_data;
    queue_entry_t head;

    // Only one request is ever in flight and it is issued only when a slot is
    // free, so its response always fits: that is the whole credit scheme.
    assign imem_req  = reset && (state_reg == IDLE) && !redirect_valid && !fifo_full;
    assign imem_addr = fpc_reg;
    assign accept    = imem_req && imem_ready;

    // A redirect kills the response and any consumer handshake in its cycle.
    assign push      = (state_reg == WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push_data = '{pc: req_pc_reg, ins: imem_rdata};

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fpc_next = fpc_reg;
        if (redirect_valid) begin
            fpc_next = word_align(redirect_pc);
        end else if (accept) begin
            fpc_next = fpc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            fpc_reg    <= RESET_PC;
            req_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            fpc_reg   <= fpc_next;
            if (accept) begin
                req_pc_reg <= fpc_reg;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (occupancy),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Head fields read as zero when empty so the uninitialised storage never leaks.
    assign out_valid = !fifo_empty;
    assign out_pc    = out_valid ? head.pc  : 32'd0;
    assign out_ins   = out_valid ? head.ins : 32'd0;
    assign out_pc8   = out_pc + 32'd8;

endmodule

// File: tb/tb_ifu_queue.sv
// Bench for ifu_queue: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based model of the fetch rules.
module tb_ifu_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        rv;
    logic [31:0] rpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        rdy;
    logic        rvld;
    logic [31:0] rdat;
    logic        out_valid;
    logic        ordy;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_fpc;
    logic [31:0] m_req_pc;
    bit          m_pending;
    bit          m_stale;
    logic [63:0] mq[$];

    // DUT values captured at the last check point
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_pc8;
    logic [2:0]  obs_occ;

    ifu_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (rv),
        .redirect_pc    (rpc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (rdy),
        .imem_rvalid    (rvld),
        .imem_rdata     (rdat),
        .out_valid      (out_valid),
        .out_ready      (ordy),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .out_pc8        (out_pc8),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fpc     = RESET_PC;
        m_req_pc  = 32'h0;
        m_pending = 0;
        m_stale   = 0;
        mq.delete();
    endtask

    // Check outputs just before the rising edge, then advance the model with
    // the inputs the DUT is about to sample.
    task automatic step();
        logic        in_rst;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        bit          acc;
        bit          do_pop;
        bit          do_push;
        @(negedge clk);
        in_rst  = (reset == 1'b0);
        e_valid = (mq.size() != 0);
        e_pc    = 32'h0;
        e_ins   = 32'h0;
        if (e_valid) begin
            e_pc  = mq[0][63:32];
            e_ins = mq[0][31:0];
        end
        e_req = !in_rst && !m_pending && !rv && (mq.size() < DEPTH);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = out_valid;
        obs_pc    = out_pc;
        obs_pc8   = out_pc8;
        obs_occ   = occupancy;
        chk("imem_req",  64'(imem_req),  64'(e_req));
        chk("imem_addr", 64'(imem_addr), 64'(m_fpc));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("out_pc",    64'(out_pc),    64'(e_pc));
        chk("out_ins",   64'(out_ins),   64'(e_ins));
        chk("out_pc8",   64'(out_pc8),   64'(32'(e_pc + 32'd8)));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        if (!in_rst) begin
            acc     = e_req && rdy;
            do_pop  = e_valid && ordy && !rv;
            do_push = m_pending && rvld && !m_stale && !rv;
            if (do_pop) begin
                $display("pop  pc=%08h ins=%08h", e_pc, e_ins);
            end
            if (m_pending && rvld) begin
                m_pending = 0;
                m_stale   = 0;
            end else if (m_pending && rv) begin
                m_stale = 1;
            end
            if (rv) begin
                mq.delete();
                m_fpc = {rpc[31:2], 2'b00};
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back({m_req_pc, rdat});
            end
            if (acc) begin
                m_pending = 1;
                m_stale   = 0;
                m_req_pc  = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single-cycle-latency memory: answer the cycle after acceptance.
    task automatic mem_cycle(input logic ready_in, input logic oready_in);
        rv   = 1'b0;
        rdy  = ready_in;
        ordy = oready_in;
        rvld = m_pending;
        rdat = $urandom;
        step();
    endtask

    initial begin
        logic [31:0] pops[$];
        logic [31:0] addrs[$];
        bit          seen;
        bit          got_first;

        reset = 1'b0;
        rv = 1'b0; rpc = 32'h0; rdy = 1'b0; rvld = 1'b0; rdat = 32'h0; ordy = 1'b0;
        model_reset();

        // reset state
        step();
        chk("rst_req", 64'(obs_req), 64'h0);
        chk("rst_pc8", 64'(obs_pc8), 64'h8);
        step();
        reset = 1'b1;

        // streaming at one instruction per two cycles
        for (int c = 0; c < 10; c++) begin
            mem_cycle(1'b1, 1'b1);
            if (c == 0) chk("t1_req_c0", 64'(obs_req), 64'h1);
            if (c == 1) chk("t1_valid_c1", 64'(obs_valid), 64'h0);
            if (c == 2) begin
                chk("t1_valid_c2", 64'(obs_valid), 64'h1);
                chk("t1_pc_c2", 64'(obs_pc), 64'h3000);
            end
            if (c == 3) chk("t1_valid_c3", 64'(obs_valid), 64'h0);
            if (c == 4) chk("t1_pc_c4", 64'(obs_pc), 64'h3004);
            if (c == 6) chk("t1_pc8_c6", 64'(obs_pc8), 64'h3010);
        end

        // back-pressure fills the queue, then drains without loss
        reset = 1'b0;
        model_reset();
        step();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) mem_cycle(1'b1, 1'b0);
        chk("t2_occ_full", 64'(obs_occ), 64'h4);
        chk("t2_req_full", 64'(obs_req), 64'h0);
        chk("t2_addr_full", 64'(obs_addr), 64'h3010);
        for (int c = 0; c < 24; c++) begin
            mem_cycle(1'b1, 1'b1);
            if (obs_valid) pops.push_back(obs_pc);
        end
        chk("t2_pop_count", 64'(pops.size() >= 8), 64'h1);
        for (int i = 0; i < 8 && i < pops.size(); i++) begin
            chk("t2_pop_pc", 64'(pops[i]), 64'(32'h3000 + 32'(4 * i)));
        end

        // redirect while a request is outstanding
        for (int c = 0; c < 10 && !m_pending; c++) begin
            rv = 1'b0; rdy = 1'b1; ordy = 1'b1; rvld = 1'b0; step();
        end
        rv = 1'b1; rpc = 32'h0000_3401; rdy = 1'b1; rvld = 1'b0; ordy = 1'b1;
        step();
        rv = 1'b0; rvld = 1'b1; rdat = 32'hDEAD_BEEF;
        step();
        chk("t3_req_drop", 64'(obs_req), 64'h0);
        chk("t3_valid_drop", 64'(obs_valid), 64'h0);
        rvld = 1'b0;
        step();
        chk("t3_req_new", 64'(obs_req), 64'h1);
        chk("t3_addr_new", 64'(obs_addr), 64'h3400);
        got_first = 0;
        for (int c = 0; c < 8; c++) begin
            mem_cycle(1'b1, 1'b1);
            if (obs_valid && !got_first) begin
                got_first = 1;
                chk("t3_first_pc", 64'(obs_pc), 64'h3400);
            end
        end
        chk("t3_got_first", 64'(got_first), 64'h1);

        // redirect coinciding with a response and a pop
        for (int c = 0; c < 20; c++) begin
            if (mq.size() >= 2 && m_pending) break;
            mem_cycle(1'b1, 1'b0);
        end
        rv = 1'b1; rpc = 32'h0000_3800; rdy = 1'b1; rvld = 1'b1; rdat = 32'h1234_5678; ordy = 1'b1;
        step();
        chk("t4_valid_before", 64'(obs_valid), 64'h1);
        rv = 1'b0; rvld = 1'b0; rdy = 1'b0;
        step();
        chk("t4_occ_flushed", 64'(obs_occ), 64'h0);
        chk("t4_req_new", 64'(obs_req), 64'h1);
        chk("t4_addr_new", 64'(obs_addr), 64'h3800);

        // fetch PC wrap at the top of the address space
        rv = 1'b1; rpc = 32'hFFFF_FFFC; rdy = 1'b1; rvld = 1'b0; ordy = 1'b1;
        step();
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            rv = 1'b0; rdy = 1'b1; ordy = 1'b1; rvld = m_pending; rdat = $urandom;
            step();
            if (obs_req) addrs.push_back(obs_addr);
            if (obs_valid && obs_pc == 32'hFFFF_FFFC) begin
                seen = 1;
                chk("t5_pc8_wrap", 64'(obs_pc8), 64'h4);
            end
        end
        chk("t5_seen_top", 64'(seen), 64'h1);
        chk("t5_addr_count", 64'(addrs.size() >= 2), 64'h1);
        if (addrs.size() >= 2) begin
            chk("t5_addr0", 64'(addrs[0]), 64'hFFFF_FFFC);
            chk("t5_addr1", 64'(addrs[1]), 64'h0);
        end

        // reset with a request outstanding, then a late response
        for (int c = 0; c < 10 && !m_pending; c++) begin
            rv = 1'b0; rdy = 1'b1; ordy = 1'b0; rvld = 1'b0; step();
        end
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_async_occ", 64'(occupancy), 64'h0);
        chk("t6_async_addr", 64'(imem_addr), 64'h3000);
        step();
        reset = 1'b1;
        rv = 1'b0; rdy = 1'b0; ordy = 1'b1; rvld = 1'b1; rdat = 32'hBAD0_BAD0;
        step();
        rvld = 1'b0;
        step();
        chk("t6_occ_late", 64'(obs_occ), 64'h0);
        chk("t6_req_after", 64'(obs_req), 64'h1);
        chk("t6_addr_after", 64'(obs_addr), 64'h3000);
        got_first = 0;
        for (int c = 0; c < 6; c++) begin
            mem_cycle(1'b1, 1'b1);
            if (obs_valid && !got_first) begin
                got_first = 1;
                chk("t6_first_pc", 64'(obs_pc), 64'h3000);
            end
        end
        chk("t6_got_first", 64'(got_first), 64'h1);

        // random traffic, including stray responses and frequent redirects
        for (int c = 0; c < 800; c++) begin
            rv   = ($urandom_range(0, 15) == 0);
            rpc  = $urandom;
            rdy  = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            rvld = m_pending ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            rdat = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
